// File: rtl/aidc_lite_decomp_line_buf.sv
// Ping-pong line assembler: collects 64-bit decompressor words into
// WORDS-word lines and hands them to a consumer with valid/ready.
// Optional feature macro: AIDC_LITE_DECOMP_LINE_BUF_ERR_EN (sticky err_o).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i/addr_i/data_i  word write (ORed decompressor bus)
//   done_i            level line-finished; rising edge closes the line
//   valid_o/ready_i   line handshake
//   data_o/mask_o     presented line and written-word mask
//   err_o             sticky overflow / bad-address flag
module aidc_lite_decomp_line_buf #(
    parameter int WORDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [3:0]         addr_i,
    input  logic [63:0]        data_i,
    input  logic               done_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WORDS*64-1:0] data_o,
    output logic [WORDS-1:0]   mask_o,
    output logic               err_o
);

    logic [63:0]      data_q [2][WORDS];
    logic [63:0]      data_d [2][WORDS];
    logic [WORDS-1:0] mask_q [2];
    logic [WORDS-1:0] mask_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             done_q;

    logic [WORDS-1:0] hit;
    logic [WORDS-1:0] fill_mask;
    logic             in_range;
    logic             wr_full;
    logic             do_wr;
    logic             close;
    logic             hs;

    always_comb begin
        data_d    = data_q;
        mask_d    = mask_q;
        full_d    = full_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        hit       = '0;
        for (int k = 0; k < WORDS; k++) begin
            hit[k] = (addr_i == 4'(k));
        end
        in_range  = ({28'd0, addr_i} < 32'(WORDS));
        wr_full   = full_q[wr_q];
        do_wr     = valid_i && in_range && !wr_full;
        fill_mask = mask_q[wr_q] | (do_wr ? hit : '0);
        // Close on a done edge or on completing the line, never on an
        // empty bank, and never while the fill bank is still occupied.
        close     = !wr_full && (fill_mask != '0) &&
                    ((done_i && !done_q) || (do_wr && (&fill_mask)));
        hs        = full_q[rd_q] && ready_i;

        // hs only when rd bank is full; close only when wr bank is not,
        // so the two never touch the same bank in one cycle.
        if (hs) begin
            for (int k = 0; k < WORDS; k++) begin
                data_d[rd_q][k] = '0;
            end
            mask_d[rd_q] = '0;
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
        if (do_wr) begin
            for (int k = 0; k < WORDS; k++) begin
                if (hit[k]) data_d[wr_q][k] = data_i;
            end
            mask_d[wr_q] = fill_mask;
        end
        if (close) begin
            full_d[wr_q] = 1'b1;
            wr_d         = ~wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < WORDS; k++) begin
                    data_q[b][k] <= '0;
                end
                mask_q[b] <= '0;
            end
            full_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            full_q <= full_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            done_q <= done_i;
        end
    end

    always_comb begin
        data_o = '0;
        for (int k = 0; k < WORDS; k++) begin
            data_o[64*k +: 64] = data_q[rd_q][k];
        end
        mask_o  = mask_q[rd_q];
        valid_o = full_q[rd_q];
    end

`ifdef AIDC_LITE_DECOMP_LINE_BUF_ERR_EN
    logic bad;
    logic err_q;

    assign bad = valid_i && (!in_range || wr_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!bad)
            else $warning("line_buf: dropped word addr=%0d", addr_i);
        end
    end
`endif
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aidc_lite_decomp_line_buf.sv
// Directed bench for aidc_lite_decomp_line_buf.
// Hand-built expected lines checked through one compare task.
module tb_aidc_lite_decomp_line_buf;

    localparam int WORDS = 8;
`ifdef AIDC_LITE_DECOMP_LINE_BUF_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic [3:0]         addr_i;
    logic [63:0]        data_i;
    logic               done_i;
    logic               valid_o;
    logic               ready_i;
    logic [WORDS*64-1:0] data_o;
    logic [WORDS-1:0]   mask_o;
    logic               err_o;

    int total = 0;
    int bad   = 0;

    aidc_lite_decomp_line_buf #(.WORDS(WORDS)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .done_i  (done_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .mask_o  (mask_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] line_of(input logic [63:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < WORDS; k++) l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        valid_i = 1'b1;
        addr_i  = 4'(a);
        data_i  = d;
        step();
        valid_i = 1'b0;
        addr_i  = '0;
        data_i  = '0;
    endtask

    logic [511:0] exp_l;

    initial begin
        rst = 1'b1; valid_i = 1'b0; addr_i = '0; data_i = '0;
        done_i = 1'b0; ready_i = 1'b1;
        step();
        chk("rst_valid", 512'(valid_o), 512'(0));
        chk("rst_data", data_o, '0);
        chk("rst_mask", 512'(mask_o), 512'(0));
        chk("rst_err", 512'(err_o), 512'(0));
        rst = 1'b0;

        // full 8-word line, consumer ready
        for (int k = 0; k < 8; k++) begin
            wr(k, 64'h1000 + 64'(k));
            if (k == 6) chk("t1_early", 512'(valid_o), 512'(0));
        end
        chk("t1_valid", 512'(valid_o), 512'(1));
        chk("t1_data", data_o, line_of(64'h1000));
        chk("t1_mask", 512'(mask_o), 512'(8'hFF));
        step();
        chk("t1_drop", 512'(valid_o), 512'(0));

        // partial line closed by done edge
        wr(2, 64'hAB);
        chk("t2_pre", 512'(valid_o), 512'(0));
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        exp_l = '0;
        exp_l[191:128] = 64'hAB;
        chk("t2_valid", 512'(valid_o), 512'(1));
        chk("t2_data", data_o, exp_l);
        chk("t2_mask", 512'(mask_o), 512'(8'h04));
        step();
        chk("t2_drop", 512'(valid_o), 512'(0));

        // back-pressure: two lines queued, 17th write dropped
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++) wr(k, 64'hA000 + 64'(k));
        chk("t3_a_valid", 512'(valid_o), 512'(1));
        for (int k = 0; k < 8; k++) wr(k, 64'hB000 + 64'(k));
        chk("t3_a_hold", data_o, line_of(64'hA000));
        wr(0, 64'hDEAD);
        chk("t3_ovf_err", 512'(err_o), 512'(ERR_EXP));
        chk("t3_a_still", data_o, line_of(64'hA000));
        chk("t3_a_mask", 512'(mask_o), 512'(8'hFF));
        ready_i = 1'b1;
        step();
        chk("t3_b_valid", 512'(valid_o), 512'(1));
        chk("t3_b_data", data_o, line_of(64'hB000));
        step();
        chk("t3_b_drop", 512'(valid_o), 512'(0));

        // clean err, empty done edge, out-of-range address
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_err_clr", 512'(err_o), 512'(0));
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        step();
        chk("t4_empty_done", 512'(valid_o), 512'(0));
        wr(9, 64'h55);
        chk("t4_bad_err", 512'(err_o), 512'(ERR_EXP));
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        step();
        chk("t4_bad_dropped", 512'(valid_o), 512'(0));

        // reset with one line presented and one half-filled
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++) wr(k, 64'hC000 + 64'(k));
        for (int k = 0; k < 4; k++) wr(k, 64'hD000 + 64'(k));
        chk("t5_pre_valid", 512'(valid_o), 512'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_valid", 512'(valid_o), 512'(0));
        chk("t5_rst_data", data_o, '0);
        chk("t5_rst_mask", 512'(mask_o), 512'(0));
        chk("t5_rst_err", 512'(err_o), 512'(0));
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) wr(k, 64'h2000 + 64'(k));
        chk("t5_valid", 512'(valid_o), 512'(1));
        chk("t5_data", data_o, line_of(64'h2000));
        step();
        chk("t5_drop", 512'(valid_o), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
